// File: rtl/fetch_pkg.sv
// Shared constants and the IF/ID payload type for the RV32I fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] DEF_NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic            valid;
    logic            misalign;
  } ifid_t;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return XLEN'(pc + 32'd4);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset > flush > stall > load.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INST = DEF_NOP_INST
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  flush,
  input  logic  stall,
  input  ifid_t d,
  output ifid_t q
);

  // A flush bubbles the slot but keeps pc/pc4 so the link value stays stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      q.inst     <= NOP_INST;
      q.pc       <= '0;
      q.pc4      <= 32'd4;
      q.valid    <= 1'b0;
      q.misalign <= 1'b0;
    end else if (flush) begin
      q.inst     <= NOP_INST;
      q.valid    <= 1'b0;
      q.misalign <= 1'b0;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and IF/ID capture.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic [31:0] o_pc,
  input  logic [31:0] i_inst,
  input  logic        i_stall_f,
  input  logic        i_flush_d,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_bubble_cnt,
`endif
  output logic [31:0] o_pc_d,
  output logic [31:0] o_pc4_d,
  output logic [31:0] o_inst_d,
  output logic        o_valid_d,
  output logic        o_misalign_d
);

  logic [31:0] pc;
  logic        misalign;
  logic        bubble;
  ifid_t       ifid_d;
  ifid_t       ifid_q;

  // Redirect targets are word-aligned; the dropped low bits are remembered as a flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc       <= RESET_PC;
      misalign <= 1'b0;
    end else if (i_redirect_valid) begin
      pc       <= {i_redirect_pc[31:2], 2'b00};
      misalign <= |i_redirect_pc[1:0];
    end else if (!i_stall_f) begin
      pc       <= pc_plus4(pc);
      misalign <= 1'b0;
    end
  end

  assign bubble = i_flush_d | i_redirect_valid;

  always_comb begin
    ifid_d.inst     = i_inst;
    ifid_d.pc       = pc;
    ifid_d.pc4      = pc_plus4(pc);
    ifid_d.valid    = 1'b1;
    ifid_d.misalign = misalign;
  end

  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk   (i_clk),
    .reset (i_reset),
    .flush (bubble),
    .stall (i_stall_f),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign o_pc         = pc;
  assign o_pc_d       = ifid_q.pc;
  assign o_pc4_d      = ifid_q.pc4;
  assign o_inst_d     = ifid_q.inst;
  assign o_valid_d    = ifid_q.valid;
  assign o_misalign_d = ifid_q.misalign;

`ifdef FETCH_PERF_CNT_EN
  // Loads and bubbles are mutually exclusive; stall edges touch neither.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_fetch_cnt  <= '0;
      o_bubble_cnt <= '0;
    end else if (bubble) begin
      o_bubble_cnt <= 32'(o_bubble_cnt + 32'd1);
    end else if (!i_stall_f) begin
      o_fetch_cnt  <= 32'(o_fetch_cnt + 32'd1);
    end
  end
`endif

endmodule
